// File: rtl/ysyx_210544_cache_split_unit.sv
// Unaligned-access splitter between an LSU/IFU and a line-based cache.
// Latches one request, issues one or two downstream accesses so that no
// access crosses a SEG_BYTES boundary, then merges, masks and optionally
// sign-extends the read data before a one-cycle completion pulse.
module ysyx_210544_cache_split_unit #(
    parameter int ADDR_W     = 64,
    parameter int DATA_BYTES = 8,
    parameter int SEG_BYTES  = 16,
    parameter int CNT_W      = 32,
    localparam int DATA_W    = 8 * DATA_BYTES,
    localparam int SZ_W      = $clog2(DATA_BYTES),
    localparam int OFFS_W    = $clog2(SEG_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [SZ_W-1:0]   i_size,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ack,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_dn_req,
    output logic              o_dn_op,
    output logic [ADDR_W-1:0] o_dn_addr,
    output logic [SZ_W-1:0]   o_dn_size,
    output logic [DATA_W-1:0] o_dn_wdata,
    input  logic              i_dn_ack,
    input  logic              i_dn_err,
    input  logic [DATA_W-1:0] i_dn_rdata,
    output logic [CNT_W-1:0]  o_split_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ0 = 2'd1, REQ1 = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q;
    logic                op_q, signed_q, cross_q;
    logic [SZ_W-1:0]     size_q, size0_q, size1_q;
    logic [ADDR_W-1:0]   addr1_q;
    logic [DATA_W-1:0]   wdata1_q, r0_q;
    logic                ack_q, err_q, dn_req_q, dn_op_q;
    logic [DATA_W-1:0]   rdata_q, dn_wdata_q;
    logic [ADDR_W-1:0]   dn_addr_q;
    logic [SZ_W-1:0]     dn_size_q;
    logic [CNT_W-1:0]    cnt_q;

    // Split computation for the request currently on the inputs.
    logic [OFFS_W:0]     end_d, room_d;
    logic                cross_d;
    logic [SZ_W-1:0]     size0_d, size1_d;
    logic [SZ_W+3:0]     sh0_d;
    logic [ADDR_W-1:0]   addr1_d;
    logic [DATA_W-1:0]   wdata1_d;

    // Merge path for the captured request.
    logic [SZ_W+3:0]     sh_r0_d;
    logic [DATA_W-1:0]   merged_d, fin_d;

    // Byte-enable mask covering the lowest nbytes bytes.
    function automatic logic [DATA_W-1:0] byte_mask(input logic [SZ_W:0] nbytes);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if ((SZ_W+1)'(b) < nbytes) begin
                m[8*b +: 8] = 8'hFF;
            end else begin
                m[8*b +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    // Replicate the top bit of a (sz+1)-byte value into the bytes above it.
    function automatic logic [DATA_W-1:0] sign_fill(input logic [DATA_W-1:0] d,
                                                    input logic [SZ_W-1:0] sz,
                                                    input logic en);
        logic [DATA_W-1:0] r;
        logic              msb;
        msb = d[{sz, 3'b111}];
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (en && ((SZ_W)'(b) > sz)) begin
                r[8*b +: 8] = {8{msb}};
            end else begin
                r[8*b +: 8] = d[8*b +: 8];
            end
        end
        return r;
    endfunction

    // Work out whether the incoming request crosses a segment and how to cut it.
    always_comb begin
        end_d    = {1'b0, i_addr[OFFS_W-1:0]} + (OFFS_W+1)'(i_size);
        room_d   = (OFFS_W+1)'(SEG_BYTES - 1) - {1'b0, i_addr[OFFS_W-1:0]};
        cross_d  = (end_d >= (OFFS_W+1)'(SEG_BYTES));
        if (cross_d) begin
            size0_d = SZ_W'(room_d);
        end else begin
            size0_d = i_size;
        end
        size1_d  = i_size - size0_d - SZ_W'(1);
        sh0_d    = {({1'b0, size0_d} + (SZ_W+1)'(1)), 3'b000};
        wdata1_d = i_wdata >> sh0_d;
        addr1_d  = {i_addr[ADDR_W-1:OFFS_W] + (ADDR_W-OFFS_W)'(1), {OFFS_W{1'b0}}};
    end

    // Combine the downstream beats and produce the final aligned read value.
    always_comb begin
        sh_r0_d = {({1'b0, size0_q} + (SZ_W+1)'(1)), 3'b000};
        if (state_q == REQ1) begin
            merged_d = r0_q | (i_dn_rdata << sh_r0_d);
        end else begin
            merged_d = i_dn_rdata & byte_mask({1'b0, size0_q} + (SZ_W+1)'(1));
        end
        fin_d = sign_fill(merged_d & byte_mask({1'b0, size_q} + (SZ_W+1)'(1)), size_q, signed_q);
    end

    // Request sequencer: capture, issue beats, complete, and count splits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            signed_q   <= 1'b0;
            cross_q    <= 1'b0;
            size_q     <= '0;
            size0_q    <= '0;
            size1_q    <= '0;
            addr1_q    <= '0;
            wdata1_q   <= '0;
            r0_q       <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            dn_req_q   <= 1'b0;
            dn_op_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_size_q  <= '0;
            dn_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        op_q       <= i_op;
                        signed_q   <= i_signed;
                        cross_q    <= cross_d;
                        size_q     <= i_size;
                        size0_q    <= size0_d;
                        size1_q    <= size1_d;
                        addr1_q    <= addr1_d;
                        wdata1_q   <= wdata1_d;
                        dn_req_q   <= 1'b1;
                        dn_op_q    <= i_op;
                        dn_addr_q  <= i_addr;
                        dn_size_q  <= size0_d;
                        dn_wdata_q <= i_wdata;
                        state_q    <= REQ0;
                        if (cross_d && (cnt_q != {CNT_W{1'b1}})) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                REQ0: begin
                    if (i_dn_ack) begin
                        dn_req_q <= 1'b0;
                        r0_q     <= merged_d;
                        if (i_dn_err || !cross_q) begin
                            ack_q   <= 1'b1;
                            err_q   <= i_dn_err;
                            state_q <= DONE;
                            if (!op_q && !i_dn_err) begin
                                rdata_q <= fin_d;
                            end
                        end else begin
                            dn_addr_q  <= addr1_q;
                            dn_size_q  <= size1_q;
                            dn_wdata_q <= wdata1_q;
                            state_q    <= REQ1;
                        end
                    end
                end
                REQ1: begin
                    // First cycle here keeps the request low between the two beats.
                    if (!dn_req_q) begin
                        dn_req_q <= 1'b1;
                    end else if (i_dn_ack) begin
                        dn_req_q <= 1'b0;
                        ack_q    <= 1'b1;
                        err_q    <= i_dn_err;
                        state_q  <= DONE;
                        if (!op_q && !i_dn_err) begin
                            rdata_q <= fin_d;
                        end
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q    <= 1'b0;
                    err_q    <= 1'b0;
                    dn_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign o_ack       = ack_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign o_dn_req    = dn_req_q;
    assign o_dn_op     = dn_op_q;
    assign o_dn_addr   = dn_addr_q;
    assign o_dn_size   = dn_size_q;
    assign o_dn_wdata  = dn_wdata_q;
    assign o_split_cnt = cnt_q;

endmodule
